// File: rtl/fifo_slave.sv
// rtl/fifo_slave.sv - bus-slave FIFO peripheral with flag, count, clear and interrupt registers
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   S_sel      slave select; an access happens only while high
//   S_wr       1 = write, 0 = read
//   S_address  register address (0x00 DATA, 0x01 FLAGS, 0x02 COUNT, 0x03 CLEAR, 0x04 INT_EN)
//   S_din      write data
//   S_dout     registered read data, holds until the next read
//   interrupt  registered level interrupt, int_en & ~empty
module fifo_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_BITS  = 3,
    parameter int ALMOST     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  S_sel,
    input  logic                  S_wr,
    input  logic [7:0]            S_address,
    input  logic [DATA_WIDTH-1:0] S_din,
    output logic [DATA_WIDTH-1:0] S_dout,
    output logic                  interrupt
);

    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_FLAGS  = 8'h01;
    localparam logic [7:0] ADDR_COUNT  = 8'h02;
    localparam logic [7:0] ADDR_CLEAR  = 8'h03;
    localparam logic [7:0] ADDR_INT_EN = 8'h04;

    // count needs one extra bit so that DEPTH itself is representable
    localparam logic [ADDR_BITS:0] FULL_LEVEL   = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AFULL_LEVEL  = (ADDR_BITS+1)'(DEPTH - ALMOST);
    localparam logic [ADDR_BITS:0] AEMPTY_LEVEL = (ADDR_BITS+1)'(ALMOST);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [ADDR_BITS:0]    count;
    logic                  wr_err;
    logic                  rd_err;
    logic                  int_en;

    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic [5:0] flags;

    assign full         = (count == FULL_LEVEL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_LEVEL);
    assign almost_empty = (count <= AEMPTY_LEVEL);
    assign flags        = {full, empty, almost_full, almost_empty, wr_err, rd_err};

    logic push;
    assign push = S_sel && S_wr && (S_address == ADDR_DATA) && !full;

    // Storage is not reset; CLEAR and reset only move pointers and count.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= S_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_err    <= 1'b0;
            rd_err    <= 1'b0;
            int_en    <= 1'b0;
            S_dout    <= '0;
            interrupt <= 1'b0;
        end else begin
            interrupt <= int_en & ~empty;
            if (S_sel) begin
                if (S_wr) begin
                    case (S_address)
                        ADDR_DATA: begin
                            if (!full) begin
                                wr_ptr <= wr_ptr + 1'b1;
                                count  <= count + 1'b1;
                            end else begin
                                wr_err <= 1'b1;
                            end
                        end
                        ADDR_CLEAR: begin
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                            count  <= '0;
                            wr_err <= 1'b0;
                            rd_err <= 1'b0;
                        end
                        ADDR_INT_EN: int_en <= S_din[0];
                        default: ;
                    endcase
                end else begin
                    case (S_address)
                        ADDR_DATA: begin
                            if (!empty) begin
                                S_dout <= mem[rd_ptr];
                                rd_ptr <= rd_ptr + 1'b1;
                                count  <= count - 1'b1;
                            end else begin
                                S_dout <= '0;
                                rd_err <= 1'b1;
                            end
                        end
                        ADDR_FLAGS:  S_dout <= DATA_WIDTH'(flags);
                        ADDR_COUNT:  S_dout <= DATA_WIDTH'(count);
                        ADDR_INT_EN: S_dout <= DATA_WIDTH'(int_en);
                        default:     S_dout <= '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_slave.sv
// tb/tb_fifo_slave.sv - directed self-checking bench for fifo_slave
module tb_fifo_slave;

    logic        clk;
    logic        reset_n;
    logic        S_sel;
    logic        S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_din;
    logic [31:0] S_dout;
    logic        interrupt;

    int checks;
    int errors;

    fifo_slave dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .S_sel     (S_sel),
        .S_wr      (S_wr),
        .S_address (S_address),
        .S_din     (S_din),
        .S_dout    (S_dout),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Each access occupies exactly one rising edge; tasks return #1 after it.
    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        S_sel = 1'b1; S_wr = 1'b1; S_address = addr; S_din = data;
        @(posedge clk); #1;
        S_sel = 1'b0; S_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
        S_sel = 1'b1; S_wr = 1'b0; S_address = addr; S_din = '0;
        @(posedge clk); #1;
        data = S_dout;
        S_sel = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    logic [31:0] rd;

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0; S_sel = 1'b0; S_wr = 1'b0; S_address = '0; S_din = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // reset state
        check("rst_dout", S_dout, 32'h0);
        check("rst_int", {31'b0, interrupt}, 32'h0);
        bus_read(8'h01, rd); check("rst_flags", rd, 32'h14);
        bus_read(8'h02, rd); check("rst_count", rd, 32'h0);

        // three pushes, three pops
        bus_write(8'h00, 32'd10);
        bus_write(8'h00, 32'd20);
        bus_write(8'h00, 32'd30);
        bus_read(8'h02, rd); check("count3", rd, 32'd3);
        bus_read(8'h00, rd); check("pop10", rd, 32'd10);
        bus_read(8'h00, rd); check("pop20", rd, 32'd20);
        bus_read(8'h00, rd); check("pop30", rd, 32'd30);
        idle(); check("dout_hold", S_dout, 32'd30);
        bus_read(8'h01, rd); check("flags_empty", rd, 32'h14);

        // fill, overflow, drain
        for (int i = 1; i <= 8; i++) bus_write(8'h00, i);
        bus_read(8'h01, rd); check("flags_full", rd, 32'h28);
        bus_read(8'h02, rd); check("count_full", rd, 32'd8);
        bus_write(8'h00, 32'd99);
        bus_read(8'h01, rd); check("flags_wr_err", rd, 32'h2A);
        for (int i = 1; i <= 8; i++) begin
            bus_read(8'h00, rd); check($sformatf("drain%0d", i), rd, i);
        end

        // underflow, then clear
        bus_read(8'h00, rd); check("pop_empty", rd, 32'h0);
        bus_read(8'h01, rd); check("flags_rd_err", rd, 32'h17);
        bus_read(8'h01, rd); check("flags_sticky", rd, 32'h17);
        bus_read(8'h07, rd); check("bad_addr", rd, 32'h0);
        bus_write(8'h03, 32'h0);
        bus_read(8'h01, rd); check("flags_clear", rd, 32'h14);
        bus_read(8'h02, rd); check("count_clear", rd, 32'h0);

        // pointer wrap-around
        for (int i = 0; i < 6; i++) bus_write(8'h00, 32'h50 + i);
        for (int i = 0; i < 6; i++) begin
            bus_read(8'h00, rd); check($sformatf("pre_wrap%0d", i), rd, 32'h50 + i);
        end
        for (int i = 0; i < 5; i++) bus_write(8'h00, 100 + i);
        bus_read(8'h02, rd); check("count_wrap", rd, 32'd5);
        for (int i = 0; i < 5; i++) begin
            bus_read(8'h00, rd); check($sformatf("wrap%0d", i), rd, 100 + i);
        end
        bus_read(8'h02, rd); check("count_wrap_end", rd, 32'h0);

        // interrupt
        bus_write(8'h04, 32'h1);
        idle(); check("int_empty", {31'b0, interrupt}, 32'h0);
        bus_read(8'h04, rd); check("int_en_rd", rd, 32'h1);
        bus_write(8'h00, 32'd7);
        check("int_lat0", {31'b0, interrupt}, 32'h0);
        idle(); check("int_set", {31'b0, interrupt}, 32'h1);
        bus_read(8'h00, rd); check("int_pop", rd, 32'd7);
        idle(); check("int_clr", {31'b0, interrupt}, 32'h0);
        bus_write(8'h00, 32'd8);
        idle(); check("int_set2", {31'b0, interrupt}, 32'h1);

        // reset while interrupt is high, with a push presented in that cycle
        reset_n = 1'b0;
        S_sel = 1'b1; S_wr = 1'b1; S_address = 8'h00; S_din = 32'hDEAD;
        @(posedge clk); #1;
        S_sel = 1'b0; S_wr = 1'b0;
        check("rst_mid_int", {31'b0, interrupt}, 32'h0);
        check("rst_mid_dout", S_dout, 32'h0);
        reset_n = 1'b1;
        bus_read(8'h04, rd); check("rst_mid_int_en", rd, 32'h0);
        bus_read(8'h02, rd); check("rst_mid_count", rd, 32'h0);
        bus_read(8'h01, rd); check("rst_mid_flags", rd, 32'h14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
